// File: rtl/regfile_alu_pkg.sv
// Shared ALU op encoding and seven-segment constants for regfile_alu_scan.
package regfile_alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS,
        OP_D2,
        OP_ADD,
        OP_SUB,
        OP_AND
    } alu_op_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-sample counter for one button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/regfile_alu_scan.sv
// Register file + button-selected ALU shown on a scanned hex display.
// Optional macro REGFILE_ALU_WB_EN: btnc with an op held writes the ALU result.
module regfile_alu_scan
    import regfile_alu_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int DEPTH           = 8,
    parameter int DIGITS          = 4,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               btn,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [$clog2(DEPTH)-1:0] raddr2,
    output logic [7:0]               segment,
    output logic [DIGITS-1:0]        anode
);

    localparam int SCW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DGW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SETTLE = DEBOUNCE_CYCLES + 2;
    localparam int STW    = $clog2(SETTLE + 1);

    logic [4:0] lvl;

    for (genvar i = 0; i < 5; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn[i]),
            .level_o(lvl[i])
        );
    end

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] d1, d2;
    alu_op_e           op;
    logic [DATA_W:0]   alu_res;

    assign d1 = regs_q[waddr];
    assign d2 = regs_q[raddr2];

    always_comb begin
        op = OP_PASS;
        if (lvl[1])      op = OP_D2;
        else if (lvl[2]) op = OP_ADD;
        else if (lvl[3]) op = OP_SUB;
        else if (lvl[4]) op = OP_AND;
        alu_res = {1'b0, d1};
        case (op)
            OP_D2:   alu_res = {1'b0, d2};
            OP_ADD:  alu_res = {1'b0, d1} + {1'b0, d2};
            OP_SUB:  alu_res = {d1 < d2, d1 - d2};
            OP_AND:  alu_res = {1'b0, d1 & d2};
            default: alu_res = {1'b0, d1};
        endcase
    end

    // A btnc held through reset release sets its level during the settle
    // window; writes stay disarmed until btnc is seen released afterwards.
    logic [STW-1:0]    settle_q;
    logic              armed_q, btnc_prev_q;
    logic              wr_pulse;
    logic [DATA_W-1:0] wval;

    assign wr_pulse = armed_q & lvl[0] & ~btnc_prev_q;

`ifdef REGFILE_ALU_WB_EN
    assign wval = (|lvl[4:1]) ? alu_res[DATA_W-1:0] : wdata;
`else
    assign wval = wdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q    <= '0;
            armed_q     <= 1'b0;
            btnc_prev_q <= 1'b0;
        end else begin
            btnc_prev_q <= lvl[0];
            if (settle_q != STW'(SETTLE)) begin
                settle_q <= settle_q + 1'b1;
            end else if (!lvl[0]) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_pulse) begin
            regs_q[waddr] <= wval;
        end
    end

    logic [DATA_W:0]    disp_q;
    logic [SCW-1:0]     scan_q;
    logic [DGW-1:0]     digit_q;
    logic [7:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  anode_q;
    logic [31:0]        disp_ext;
    logic [3:0]         nib;

    always_comb begin
        disp_ext   = 32'(disp_q[DATA_W-1:0]);
        nib        = 4'(disp_ext >> {digit_q, 2'b00});
        seg_d      = SEG_OFF;
        seg_d[7]   = !((digit_q == '0) && disp_q[DATA_W]);
        seg_d[6:0] = ((int'(digit_q) * 4) >= DATA_W) ? SEG_BLANK : hex_to_seg(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q  <= '0;
            scan_q  <= '0;
            digit_q <= '0;
            seg_q   <= SEG_OFF;
            anode_q <= '1;
        end else begin
            disp_q  <= alu_res;
            seg_q   <= seg_d;
            anode_q <= ~(DIGITS'(1) << digit_q);
            if (scan_q == SCW'(REFRESH_DIV - 1)) begin
                scan_q  <= '0;
                digit_q <= (digit_q == DGW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
        end
    end

    assign segment = seg_q;
    assign anode   = anode_q;

endmodule

// File: tb/tb_regfile_alu_scan.sv
// Bench for regfile_alu_scan: cycle-level reference model plus pinned digit values.
module tb_regfile_alu_scan;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int DIGITS = 4;
    localparam int R      = 8;
    localparam int D      = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        btn;
    logic [DW-1:0]     wdata;
    logic [2:0]        waddr, raddr2;
    logic [7:0]        segment;
    logic [DIGITS-1:0] anode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_alu_scan #(
        .DATA_W(DW), .DEPTH(DEPTH), .DIGITS(DIGITS),
        .REFRESH_DIV(R), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .wdata(wdata),
        .waddr(waddr), .raddr2(raddr2), .segment(segment), .anode(anode)
    );

    // Reference model state
    logic [DW-1:0]     m_regs [DEPTH];
    logic [DW:0]       m_disp;
    logic [4:0]        m_p1, m_p2, m_lvl, m_lvl_prev;
    logic [4:0]        m_win [D];
    bit                m_armed;
    int unsigned       m_n, m_writes;
    logic [7:0]        exp_seg;
    logic [DIGITS-1:0] exp_anode;

    function automatic logic [6:0] hexseg(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
           12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [DW:0] ref_alu(input int a, input int b, input logic [4:0] l);
        int r;
        bit f;
        f = 0;
        if (l[1])      r = b;
        else if (l[2]) begin r = a + b; f = (r >= (1 << DW)); end
        else if (l[3]) begin r = a - b; f = (a < b); end
        else if (l[4]) r = a & b;
        else           r = a;
        r = r & ((1 << DW) - 1);
        return {f, r[DW-1:0]};
    endfunction

    function automatic logic [7:0] ref_seg(input int g, input logic [DW:0] disp);
        logic [7:0] s;
        s    = 8'hFF;
        s[7] = !(g == 0 && disp[DW]);
        if (4 * g < DW) s[6:0] = hexseg((int'(disp[DW-1:0]) >> (4 * g)) & 15);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        for (int j = 0; j < D; j++) m_win[j] = '0;
        m_disp = '0; m_p1 = '0; m_p2 = '0; m_lvl = '0; m_lvl_prev = '0;
        m_armed = 0; m_n = 0;
        exp_seg = 8'hFF; exp_anode = '1;
    endtask

    task automatic model_step();
        logic [DW:0]       alu;
        logic [DIGITS-1:0] one;
        int                g;
        bit                flip;
        one       = 1;
        g         = (m_n / R) % DIGITS;
        exp_anode = ~(one << g);
        exp_seg   = ref_seg(g, m_disp);
        alu       = ref_alu(m_regs[waddr], m_regs[raddr2], m_lvl);
        m_disp    = alu;
        if (m_armed && m_lvl[0] && !m_lvl_prev[0]) begin
`ifdef REGFILE_ALU_WB_EN
            m_regs[waddr] = (|m_lvl[4:1]) ? alu[DW-1:0] : wdata;
`else
            m_regs[waddr] = wdata;
`endif
            m_writes++;
        end
        if (m_n >= D + 2 && !m_lvl[0]) m_armed = 1;
        m_lvl_prev = m_lvl;
        for (int j = 0; j < D - 1; j++) m_win[j] = m_win[j+1];
        m_win[D-1] = m_p2;
        for (int b = 0; b < 5; b++) begin
            flip = 1;
            for (int j = 0; j < D; j++) if (m_win[j][b] == m_lvl[b]) flip = 0;
            if (flip) m_lvl[b] = ~m_lvl[b];
        end
        m_p2 = m_p1;
        m_p1 = btn;
        m_n++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_writes = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            chk("segment", segment, exp_seg);
            chk("anode", 8'(anode), 8'(exp_anode));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [DW-1:0] v);
        btn[4:1] = '0;
        waddr = a; wdata = v; btn[0] = 1'b1;
        cyc(10);
        btn[0] = 1'b0;
        cyc(10);
    endtask

    task automatic expect_digit(input string name, input int g, input logic [7:0] exp);
        logic [DIGITS-1:0] want;
        int k;
        want = ~(DIGITS'(1) << g);
        k = 0;
        do begin
            @(posedge clk); #2; k++;
        end while (anode !== want && k < 64);
        if (anode !== want) begin
            checks++; errors++;
            $display("FAIL %s: digit %0d not selected within 64 cycles, anode %h", name, g, anode);
        end else begin
            chk(name, segment, exp);
            chk({name, "_model"}, exp_seg, exp);
        end
    endtask

    initial begin
        int unsigned w0;
        int k;
        rst_n = 1'b0; btn = '0; wdata = '0; waddr = '0; raddr2 = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(12);
        expect_digit("post_reset_d0", 0, 8'hC0);

        // Hex display of a register, upper digits blank
        write_reg(3'd2, 8'h3C);
        write_reg(3'd5, 8'h05);
        waddr = 3'd2; raddr2 = 3'd5;
        cyc(4);
        expect_digit("pass_d0", 0, 8'hC6);
        expect_digit("pass_d1", 1, 8'hB0);
        expect_digit("pass_d2", 2, 8'hFF);
        expect_digit("pass_d3", 3, 8'hFF);

        // Add, without and with carry
        btn[2] = 1'b1; cyc(10);
        expect_digit("add_d0", 0, 8'hF9);
        expect_digit("add_d1", 1, 8'h99);
        btn = '0; cyc(8);
        write_reg(3'd2, 8'hFF);
        write_reg(3'd5, 8'h02);
        waddr = 3'd2;
        btn[2] = 1'b1; cyc(10);
        expect_digit("carry_d0", 0, 8'h79);
        expect_digit("carry_d1", 1, 8'hC0);
        btn = '0; cyc(8);

        // Priority r over d, then subtract with borrow
        btn[1] = 1'b1; btn[3] = 1'b1; cyc(10);
        expect_digit("prio_d0", 0, 8'hA4);
        expect_digit("prio_d1", 1, 8'hC0);
        btn = '0; cyc(8);
        write_reg(3'd2, 8'h02);
        write_reg(3'd5, 8'h05);
        waddr = 3'd2;
        btn[3] = 1'b1; cyc(10);
        expect_digit("sub_d0", 0, 8'h21);
        expect_digit("sub_d1", 1, 8'h8E);
        btn = '0; cyc(8);

        // Bouncing btnc yields a single write
        waddr = 3'd6; wdata = 8'hA7;
        w0 = m_writes;
        btn[0] = 1'b1; cyc(1);
        btn[0] = 1'b0; cyc(1);
        btn[0] = 1'b1; cyc(12);
        wdata = 8'h5B; cyc(8);
        btn[0] = 1'b0; cyc(10);
        chk("bounce_writes", 8'(m_writes - w0), 8'd1);
        expect_digit("bounce_d0", 0, 8'hF8);
        expect_digit("bounce_d1", 1, 8'h88);

        // Writeback option
        write_reg(3'd2, 8'h10);
        write_reg(3'd5, 8'h01);
        waddr = 3'd2; raddr2 = 3'd5; wdata = 8'h77;
        btn[2] = 1'b1; cyc(10);
        btn[0] = 1'b1; cyc(10);
        btn = '0; cyc(10);
`ifdef REGFILE_ALU_WB_EN
        expect_digit("wb_d0", 0, 8'hF9);
        expect_digit("wb_d1", 1, 8'hF9);
`else
        expect_digit("wb_d0", 0, 8'hF8);
        expect_digit("wb_d1", 1, 8'hF8);
`endif

        // Reset mid-scan on digit 2, btnc held through release
        k = 0;
        do begin @(posedge clk); #2; k++; end while (anode !== 4'hB && k < 64);
        chk("reach_digit2", 8'(anode), 8'h0B);
        #1 rst_n = 1'b0;
        btn[0] = 1'b1; wdata = 8'h99;
        #1;
        chk("rst_anode", 8'(anode), 8'h0F);
        chk("rst_segment", segment, 8'hFF);
        cyc(2);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("release_anode", 8'(anode), 8'h0E);
        chk("release_segment", segment, 8'hC0);
        cyc(20);
        btn[0] = 1'b0; cyc(10);
        expect_digit("held_nowrite_d0", 0, 8'hC0);
        write_reg(3'd2, 8'h99);
        waddr = 3'd2; cyc(4);
        expect_digit("repress_d0", 0, 8'h90);
        expect_digit("repress_d1", 1, 8'h90);

        // Randomized operation against the model
        for (int s = 0; s < 300; s++) begin
            wdata  = DW'($urandom);
            waddr  = 3'($urandom);
            raddr2 = 3'($urandom);
            btn    = 5'($urandom);
            cyc($urandom_range(1, 10));
        end
        btn = '0;
        cyc(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
